// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the bit counter width helper.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit counter is still needed when WIDTH=1, so never return 0.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// One-bit full adder used as the bit-slice of the serial adder.
module adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, feeds one bit pair
// per clock LSB first through a full adder, and presents a parallel result.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .c   (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  assign res_nxt  = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry   <= cin;
            bit_cnt <= '0;
            res_sr  <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry   <= fa_cout;
          bit_cnt <= bit_cnt + CNT_W'(1);
          res_sr  <= res_nxt;
          if (last_bit) begin
            sum_out <= res_nxt;
            cout    <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt8 = 0;
  int         done_cnt1 = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] last8 = '0;
  logic [8:0] e8;
  logic [1:0] e1;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done_cnt8++;
      if (q8.size() == 0) check("done8_unexpected", 64'(1), 64'(0));
      else begin
        e8 = q8.pop_front();
        check("result8", 64'({cout8, sum8}), 64'(e8));
        last8 = e8;
      end
    end
    if (rst_n && done1) begin
      done_cnt1++;
      if (q1.size() == 0) check("done1_unexpected", 64'(1), 64'(0));
      else begin
        e1 = q1.pop_front();
        check("result1", 64'({cout1, sum1}), 64'(e1));
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy8"}, 64'(busy8), 64'(0));
    check({tag, "_done8"}, 64'(done8), 64'(0));
    check({tag, "_res8"}, 64'({cout8, sum8}), 64'(0));
    check({tag, "_busy1"}, 64'(busy1), 64'(0));
    check({tag, "_res1"}, 64'({cout1, sum1}), 64'(0));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inject);
    int n0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    n0 = done_cnt8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy8_run", 64'(busy8), 64'(1));
      check("done8_run", 64'(done8), 64'(0));
      check("hold8", 64'({cout8, sum8}), 64'(last8));
      if (i == inject) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    @(negedge clk);
    check("done8_pulse", 64'(done8), 64'(1));
    check("busy8_done", 64'(busy8), 64'(0));
    #1;
    check("done8_count", 64'(done_cnt8 - n0), 64'(1));
  endtask

  task automatic run1(input logic a, input logic b, input logic c);
    @(posedge clk); #1;
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back({1'b0, a} + {1'b0, b} + 2'(c));
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    @(negedge clk);
    check("busy1_run", 64'(busy1), 64'(1));
    check("done1_run", 64'(done1), 64'(0));
    @(negedge clk);
    check("done1_pulse", 64'(done1), 64'(1));
    check("busy1_done", 64'(busy1), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check_idle_zero("in_reset");
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle_zero("idle");
    end

    run8(8'hFF, 8'h01, 1'b0, -1);
    run8(8'hA5, 8'h5A, 1'b1, -1);
    run8(8'h3C, 8'h0F, 1'b0, -1);
    run8(8'h01, 8'h01, 1'b0, 2);

    // Abort an addition four edges after it was accepted.
    @(posedge clk); #1;
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_zero("mid_reset");
    check("mid_reset_state", 64'(dut8.state), 64'(0));
    q8.delete();
    last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h10, 8'h20, 1'b0, -1);
    check("after_reset_sum", 64'({cout8, sum8}), 64'(9'h030));

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      run1(v[2], v[1], v[0]);
    end

    repeat (3) @(negedge clk);
    check("pending8", 64'(q8.size()), 64'(0));
    check("pending1", 64'(q1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
